// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmit and receive sides.
package uart_pkg;
  localparam int unsigned UART_BAUD_DEF  = 20;  // clock cycles per serial bit
  localparam int unsigned UART_DATA_BITS = 8;   // data bits per frame
  localparam int unsigned UART_CNT_W     = 14;  // bit timer width, N up to 16383

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;
endpackage

// File: rtl/uart_tx_bit_timer.sv
// Loadable down-counter timing one serial bit; restarts on load so each
// frame is phase-aligned to its own accept edge.
module uart_tx_bit_timer
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_RATE_NUMBER = UART_BAUD_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic expire
);
  localparam logic [UART_CNT_W-1:0] RELOAD = UART_CNT_W'(BAUD_RATE_NUMBER - 1);

  logic [UART_CNT_W-1:0] cnt_q, cnt_d;

  // Reload on accept or on expiry, otherwise count down.
  always_comb begin
    cnt_d = cnt_q - UART_CNT_W'(1);
    if (load || (cnt_q == '0)) cnt_d = RELOAD;
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= RELOAD;
    else        cnt_q <= cnt_d;
  end

  assign expire = (cnt_q == '0);
endmodule

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter: one byte per valid/ready handshake, LSB first.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_RATE_NUMBER = UART_BAUD_DEF,
  parameter int unsigned DATA_BITS        = UART_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy
);
  uart_state_e          state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0]           idx_q, idx_d;
  logic                 tx_q, tx_d;
  logic                 accept, expire;

  assign accept = tx_valid && (state_q == IDLE);

  uart_tx_bit_timer #(.BAUD_RATE_NUMBER(BAUD_RATE_NUMBER)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (accept),
    .expire (expire)
  );

  // State, datapath and line registers; reset abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
    end
  end

  // Next state: each non-idle state advances on bit-timer expiry.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = START;
      START:   if (expire) state_d = DATA;
      DATA:    if (expire && (idx_q == 3'd7)) state_d = STOP;
      STOP:    if (expire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values; tx only moves on accept or expiry so it never glitches.
  always_comb begin
    shift_d = shift_q;
    idx_d   = idx_q;
    tx_d    = tx_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          shift_d = tx_data;
          idx_d   = '0;
          tx_d    = 1'b0;
        end
      end
      START: if (expire) tx_d = shift_q[0];
      DATA: begin
        if (expire) begin
          shift_d = shift_q >> 1;
          idx_d   = idx_q + 3'd1;
          tx_d    = (idx_q == 3'd7) ? 1'b1 : shift_q[1];
        end
      end
      STOP:    if (expire) tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
  end

  // Handshake/status outputs decoded from state.
  always_comb begin
    tx_ready = (state_q == IDLE);
    tx_busy  = (state_q != IDLE);
  end

  assign tx = tx_q;
endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: N=20 and N=2 instances, frame tables,
// reset corner cases, and a random loopback through a behavioural receiver.
module tb_uart_transmitter;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] d20, d2;
  logic       v20, v2;
  logic       tx20, r20, b20, tx2, r2, b2;

  always #5 clk = ~clk;

  uart_transmitter #(.BAUD_RATE_NUMBER(20)) dut20 (
    .clk(clk), .rst_n(rst_n), .tx_data(d20), .tx_valid(v20),
    .tx_ready(r20), .tx(tx20), .tx_busy(b20)
  );
  uart_transmitter #(.BAUD_RATE_NUMBER(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .tx_data(d2), .tx_valid(v2),
    .tx_ready(r2), .tx(tx2), .tx_busy(b2)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit         sel;    // 0: N=20 instance, 1: N=2 instance
    logic [7:0] data;
    logic [9:0] frame;  // hand-written line bits, bit0 = start ... bit9 = stop
    bit         hold;   // keep tx_valid high into the next entry
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] outs(input bit sel);
    return sel ? {tx2, r2, b2} : {tx20, r20, b20};
  endfunction

  task automatic drive(input bit sel, input logic v, input logic [7:0] d);
    if (sel) begin v2 = v; d2 = d; end
    else     begin v20 = v; d20 = d; end
  endtask

  // Called at a negedge with the instance idle; checks every cycle of the frame.
  task automatic run_frame(input bit sel, input logic [7:0] data,
                           input logic [9:0] frame, input bit hold);
    int n;
    logic [2:0] o;
    n = sel ? 2 : 20;
    o = outs(sel);
    chk("pre_ready", 32'(o[1]), 32'd1);
    drive(sel, 1'b1, data);
    @(posedge clk);
    for (int c = 1; c <= 10 * n; c++) begin
      @(negedge clk);
      if (c == 1) drive(sel, 1'b1, ~data);  // must not leak into the frame
      o = outs(sel);
      chk($sformatf("frame_%0h_c%0d", data, c), 32'(o), 32'({frame[(c-1)/n], 1'b0, 1'b1}));
    end
    @(negedge clk);
    if (!hold) drive(sel, 1'b0, 8'h00);
    o = outs(sel);
    chk($sformatf("idle_after_%0h", data), 32'(o), 32'b110);
  endtask

  vec_t tbl[4];
  logic [7:0] exp_q[$];

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] o;
    rst_n = 1'b0;
    v20 = 1'b1; d20 = 8'hA5;
    v2  = 1'b1; d2  = 8'h5A;

    // Reset held 3 cycles with valid high: nothing starts.
    repeat (3) begin
      @(negedge clk);
      chk("rst20", 32'(outs(1'b0)), 32'b110);
      chk("rst2",  32'(outs(1'b1)), 32'b110);
    end
    v20 = 1'b0; v2 = 1'b0;
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("post_rst_idle", 32'(outs(1'b0)), 32'b110);
    end

    // Frame table: 0xA5 single, 0x00 -> 0xFF back-to-back, 0x55 at N=2.
    tbl[0] = '{1'b0, 8'hA5, 10'h34A, 1'b0};
    tbl[1] = '{1'b0, 8'h00, 10'h200, 1'b1};
    tbl[2] = '{1'b0, 8'hFF, 10'h3FE, 1'b0};
    tbl[3] = '{1'b1, 8'h55, 10'h2AA, 1'b0};
    for (int i = 0; i < 4; i++) begin
      run_frame(tbl[i].sel, tbl[i].data, tbl[i].frame, tbl[i].hold);
      if (!tbl[i].hold) begin
        repeat (3) begin
          @(negedge clk);
          chk("gap_idle", 32'(outs(tbl[i].sel)), 32'b110);
        end
      end
    end

    // Reset during data bit 3 of 0x3C (bit 3 = 1, cycles 81..100 after accept).
    v20 = 1'b1; d20 = 8'h3C;
    @(posedge clk);
    @(negedge clk);
    v20 = 1'b0;
    repeat (84) @(negedge clk);
    chk("mid_bit3", 32'(outs(1'b0)), 32'b101);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_mid", 32'(outs(1'b0)), 32'b110);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("rst_mid_idle", 32'(outs(1'b0)), 32'b110);
    end
    run_frame(1'b0, 8'h81, 10'h302, 1'b0);

    // Random loopback at N=2 through a mid-bit sampling receiver model.
    fork
      begin : driver
        int w;
        logic [7:0] b;
        for (int i = 0; i < 256; i++) begin
          w = 0;
          while (!r2 && w < 100) begin @(negedge clk); w++; end
          if (!r2) begin chk("lb_ready_timeout", 32'(r2), 32'd1); break; end
          b = 8'($urandom);
          exp_q.push_back(b);
          v2 = 1'b1; d2 = b;
          @(posedge clk);
          @(negedge clk);
          v2 = 1'b0; d2 = 8'($urandom);
          repeat ($urandom_range(0, 2)) @(negedge clk);
        end
      end
      begin : monitor
        int w;
        logic [7:0] got;
        logic st, sp;
        for (int f = 0; f < 256; f++) begin
          w = 0;
          while (tx2 !== 1'b0 && w < 200) begin @(negedge clk); w++; end
          if (tx2 !== 1'b0) begin chk("lb_start_timeout", 32'(tx2), 32'd0); break; end
          @(negedge clk);          // middle of start bit (N/2 = 1)
          st = tx2;
          for (int j = 0; j < 8; j++) begin
            repeat (2) @(negedge clk);
            got[j] = tx2;
          end
          repeat (2) @(negedge clk);
          sp = tx2;
          chk($sformatf("lb_framing_%0d", f), 32'({sp, st}), 32'b10);
          if (exp_q.size() == 0) chk("lb_unexpected_frame", 32'd1, 32'd0);
          else chk($sformatf("lb_data_%0d", f), 32'(got), 32'(exp_q.pop_front()));
          @(negedge clk);
        end
      end
    join
    chk("lb_all_consumed", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
